nes_addr_mode_decoder: RTL

- Front-end fetch/decode sequencer for the 6502 core in the NES design; it is the producer of the per-instruction addressing-mode flags.
- Per request it reads the opcode at a given PC, classifies the addressing mode, fetches 0-2 operand bytes, and presents one-hot mode flags, opcode, operand and next PC under a valid/ack handshake.
- Its flag outputs connect directly to the mode-flag inputs of the downstream trace and execute logic.

---
 rtl/nes_addr_mode_decoder_if.sv | 45 ++++
 rtl/nes_addr_mode_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_addr_mode_decoder_if.sv
// Fetch/decode bus between the 6502 addressing-mode decoder, its opcode memory
// and the downstream consumer of the decoded instruction.
interface nes_addr_mode_decoder_if;
   logic        fetch_req;
   logic [15:0] pc_in;
   logic        fetch_ready;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        decode_valid;
   logic        decode_ack;
   logic [7:0]  instruction;
   logic [15:0] operand;
   logic [1:0]  op_len;
   logic [15:0] next_pc;
   logic        immediate;
   logic        absolute;
   logic        zpg_absolute;
   logic        implied;
   logic        accumulator;
   logic        abs_indexed_x;
   logic        abs_indexed_y;
   logic        zpg_indexed_x;
   logic        zpg_indexed_y;
   logic        indirect;
   logic        indirect_x;
   logic        indirect_y;
   logic        relative;

   modport master (
      input  fetch_req, pc_in, mem_data, decode_ack,
      output fetch_ready, mem_rd, mem_addr, decode_valid, instruction, operand,
             op_len, next_pc, immediate, absolute, zpg_absolute, implied,
             accumulator, abs_indexed_x, abs_indexed_y, zpg_indexed_x,
             zpg_indexed_y, indirect, indirect_x, indirect_y, relative
   );

   modport slave (
      output fetch_req, pc_in, mem_data, decode_ack,
      input  fetch_ready, mem_rd, mem_addr, decode_valid, instruction, operand,
             op_len, next_pc, immediate, absolute, zpg_absolute, implied,
             accumulator, abs_indexed_x, abs_indexed_y, zpg_indexed_x,
             zpg_indexed_y, indirect, indirect_x, indirect_y, relative
   );
endinterface

// File: rtl/nes_addr_mode_decoder.sv
// 6502 fetch/decode sequencer: reads opcode plus 0-2 operand bytes and presents
// one-hot addressing-mode flags, operand and next PC under a valid/ack handshake.
module nes_addr_mode_decoder (
   input logic                    clk,
   input logic                    rst,
   nes_addr_mode_decoder_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, RD_OP, CAP_OP, RD_LO, CAP_LO, RD_HI, CAP_HI, DONE
   } state_e;

   typedef enum logic [3:0] {
      M_UNK, M_IMM, M_ABS, M_ZPG, M_IMP, M_ACC, M_ABX, M_ABY,
      M_ZPX, M_ZPY, M_IND, M_INX, M_INY, M_REL
   } mode_e;

   // Opcode is split into aaa/bbb/cc; cc selects which column table applies.
   function automatic mode_e decode_mode(input logic [7:0] op);
      logic [2:0] aaa;
      logic [2:0] bbb;
      mode_e      m;
      aaa = op[7:5];
      bbb = op[4:2];
      m   = M_UNK;
      case (op[1:0])
         2'b01: begin
            case (bbb)
               3'b000:  m = M_INX;
               3'b001:  m = M_ZPG;
               3'b010:  m = (op == 8'h89) ? M_UNK : M_IMM;
               3'b011:  m = M_ABS;
               3'b100:  m = M_INY;
               3'b101:  m = M_ZPX;
               3'b110:  m = M_ABY;
               3'b111:  m = M_ABX;
               default: m = M_UNK;
            endcase
         end
         2'b10: begin
            case (bbb)
               3'b000:  m = (op == 8'hA2) ? M_IMM : M_UNK;
               3'b001:  m = M_ZPG;
               3'b010:  m = (aaa < 3'd4) ? M_ACC : M_IMP;
               3'b011:  m = M_ABS;
               3'b101:  m = (aaa == 3'd4 || aaa == 3'd5) ? M_ZPY : M_ZPX;
               3'b110:  m = (op == 8'h9A || op == 8'hBA) ? M_IMP : M_UNK;
               3'b111:  m = (op == 8'hBE) ? M_ABY : M_ABX;
               default: m = M_UNK;
            endcase
         end
         2'b00: begin
            case (bbb)
               3'b000: begin
                  if (op == 8'h00 || op == 8'h40 || op == 8'h60) m = M_IMP;
                  else if (op == 8'h20)                          m = M_ABS;
                  else if (aaa >= 3'd5)                          m = M_IMM;
                  else                                           m = M_UNK;
               end
               3'b001:  m = (aaa == 3'd1 || aaa >= 3'd4) ? M_ZPG : M_UNK;
               3'b010:  m = M_IMP;
               3'b011: begin
                  if (op == 8'h6C)       m = M_IND;
                  else if (aaa != 3'd0)  m = M_ABS;
                  else                   m = M_UNK;
               end
               3'b100:  m = M_REL;
               3'b101:  m = (op == 8'h94 || op == 8'hB4) ? M_ZPX : M_UNK;
               3'b110:  m = M_IMP;
               3'b111:  m = (op == 8'hBC) ? M_ABX : M_UNK;
               default: m = M_UNK;
            endcase
         end
         default: m = M_UNK;
      endcase
      return m;
   endfunction

   function automatic logic [1:0] mode_len(input mode_e m);
      case (m)
         M_ABS, M_ABX, M_ABY, M_IND: return 2'd3;
         M_IMP, M_ACC, M_UNK:        return 2'd1;
         default:                    return 2'd2;
      endcase
   endfunction

   // Bit order matches the flag port order, immediate in bit 0.
   function automatic logic [12:0] mode_flags(input mode_e m);
      case (m)
         M_IMM:   return 13'b0_0000_0000_0001;
         M_ABS:   return 13'b0_0000_0000_0010;
         M_ZPG:   return 13'b0_0000_0000_0100;
         M_IMP:   return 13'b0_0000_0000_1000;
         M_ACC:   return 13'b0_0000_0001_0000;
         M_ABX:   return 13'b0_0000_0010_0000;
         M_ABY:   return 13'b0_0000_0100_0000;
         M_ZPX:   return 13'b0_0000_1000_0000;
         M_ZPY:   return 13'b0_0001_0000_0000;
         M_IND:   return 13'b0_0010_0000_0000;
         M_INX:   return 13'b0_0100_0000_0000;
         M_INY:   return 13'b0_1000_0000_0000;
         M_REL:   return 13'b1_0000_0000_0000;
         default: return 13'b0_0000_0000_0000;
      endcase
   endfunction

   state_e      state_r;
   mode_e       mode_r;
   logic [15:0] pc_r;
   logic        fetch_ready_r;
   logic        mem_rd_r;
   logic [15:0] mem_addr_r;
   logic        decode_valid_r;
   logic [7:0]  instruction_r;
   logic [15:0] operand_r;
   logic [1:0]  op_len_r;
   logic [15:0] next_pc_r;
   logic [12:0] flags_r;
   mode_e       mode_s;
   logic [1:0]  len_s;

   assign mode_s = decode_mode(bus.mem_data);
   assign len_s  = mode_len(mode_s);

   // Sequencer: one read per byte, data captured the cycle after each strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         mode_r         <= M_UNK;
         pc_r           <= 16'h0000;
         fetch_ready_r  <= 1'b1;
         mem_rd_r       <= 1'b0;
         mem_addr_r     <= 16'h0000;
         decode_valid_r <= 1'b0;
         instruction_r  <= 8'h00;
         operand_r      <= 16'h0000;
         op_len_r       <= 2'd1;
         next_pc_r      <= 16'h0000;
         flags_r        <= 13'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.fetch_req) begin
                  pc_r          <= bus.pc_in;
                  mem_rd_r      <= 1'b1;
                  mem_addr_r    <= bus.pc_in;
                  operand_r     <= 16'h0000;
                  fetch_ready_r <= 1'b0;
                  state_r       <= RD_OP;
               end else begin
                  fetch_ready_r <= 1'b1;
               end
            end
            RD_OP: begin
               mem_rd_r <= 1'b0;
               state_r  <= CAP_OP;
            end
            CAP_OP: begin
               instruction_r <= bus.mem_data;
               mode_r        <= mode_s;
               op_len_r      <= len_s;
               next_pc_r     <= pc_r + {14'd0, len_s};
               if (len_s == 2'd1) begin
                  state_r <= DONE;
               end else begin
                  mem_rd_r   <= 1'b1;
                  mem_addr_r <= pc_r + 16'd1;
                  state_r    <= RD_LO;
               end
            end
            RD_LO: begin
               mem_rd_r <= 1'b0;
               state_r  <= CAP_LO;
            end
            CAP_LO: begin
               operand_r[7:0] <= bus.mem_data;
               if (op_len_r == 2'd2) begin
                  state_r <= DONE;
               end else begin
                  mem_rd_r   <= 1'b1;
                  mem_addr_r <= pc_r + 16'd2;
                  state_r    <= RD_HI;
               end
            end
            RD_HI: begin
               mem_rd_r <= 1'b0;
               state_r  <= CAP_HI;
            end
            CAP_HI: begin
               operand_r[15:8] <= bus.mem_data;
               state_r         <= DONE;
            end
            DONE: begin
               // First DONE cycle raises valid; ack is honoured only once valid is seen.
               if (!decode_valid_r) begin
                  decode_valid_r <= 1'b1;
                  flags_r        <= mode_flags(mode_r);
               end else if (bus.decode_ack) begin
                  decode_valid_r <= 1'b0;
                  flags_r        <= 13'd0;
                  fetch_ready_r  <= 1'b1;
                  state_r        <= IDLE;
               end else begin
                  decode_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r        <= IDLE;
               mem_rd_r       <= 1'b0;
               fetch_ready_r  <= 1'b1;
               decode_valid_r <= 1'b0;
               flags_r        <= 13'd0;
            end
         endcase
      end
   end

   assign bus.fetch_ready   = fetch_ready_r;
   assign bus.mem_rd        = mem_rd_r;
   assign bus.mem_addr      = mem_addr_r;
   assign bus.decode_valid  = decode_valid_r;
   assign bus.instruction   = instruction_r;
   assign bus.operand       = operand_r;
   assign bus.op_len        = op_len_r;
   assign bus.next_pc       = next_pc_r;
   assign bus.immediate     = flags_r[0];
   assign bus.absolute      = flags_r[1];
   assign bus.zpg_absolute  = flags_r[2];
   assign bus.implied       = flags_r[3];
   assign bus.accumulator   = flags_r[4];
   assign bus.abs_indexed_x = flags_r[5];
   assign bus.abs_indexed_y = flags_r[6];
   assign bus.zpg_indexed_x = flags_r[7];
   assign bus.zpg_indexed_y = flags_r[8];
   assign bus.indirect      = flags_r[9];
   assign bus.indirect_x    = flags_r[10];
   assign bus.indirect_y    = flags_r[11];
   assign bus.relative      = flags_r[12];
endmodule
